// File: rtl/serial_cmp_pkg.sv
// Shared types for the bit-serial comparator: FSM states, verdict encoding
// and the verdict-to-one-hot {gt,lt,eq} mapping.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        V_EQ = 2'd0,
        V_GT = 2'd1,
        V_LT = 2'd2
    } verdict_e;

    function automatic logic [2:0] verdict_onehot(input verdict_e v);
        logic [2:0] res;
        case (v)
            V_GT:    res = 3'b100;
            V_LT:    res = 3'b010;
            default: res = 3'b001;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/comparator_one_bit.sv
// Single-bit magnitude compare cell producing mutually exclusive G/L/E flags.
module comparator_one_bit (
    input  logic a,
    input  logic b,
    output logic gt,
    output logic lt,
    output logic eq
);

    assign gt = a & ~b;
    assign lt = ~a & b;
    assign eq = ~(a ^ b);

endmodule

// File: rtl/serial_compare_ctrl.sv
// Bit-serial MSB-first comparator sequencer sharing one comparator_one_bit cell.
// Define SERIAL_CMP_EARLY_EXIT_EN to finish on the first differing bit instead of running constant-time.
module serial_compare_ctrl
    import serial_cmp_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             gt,
    output logic             lt,
    output logic             eq,
    output logic             busy
);

    localparam int IDX_W = $clog2(WIDTH);
    localparam logic [IDX_W-1:0] IDX_MSB = IDX_W'(WIDTH - 1);

    state_e           state_q, state_d;
    verdict_e         verdict_q, verdict_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    logic cell_gt, cell_lt, cell_eq;
    logic bit_gt;
    logic first_diff;
    logic run_last;
    logic [2:0] onehot;

    comparator_one_bit u_cell (
        .a  (a_q[idx_q]),
        .b  (b_q[idx_q]),
        .gt (cell_gt),
        .lt (cell_lt),
        .eq (cell_eq)
    );

    // In two's complement a set sign bit means the smaller value, so the MSB verdict flips.
    assign bit_gt     = (SIGNED && (idx_q == IDX_MSB)) ? cell_lt : cell_gt;
    assign first_diff = (verdict_q == V_EQ) && !cell_eq;

`ifdef SERIAL_CMP_EARLY_EXIT_EN
    assign run_last = (idx_q == '0) || first_diff;
`else
    assign run_last = (idx_q == '0);
`endif

    always_comb begin
        state_d   = state_q;
        verdict_d = verdict_q;
        a_d       = a_q;
        b_d       = b_q;
        idx_d     = idx_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_d       = a;
                    b_d       = b;
                    idx_d     = IDX_MSB;
                    verdict_d = V_EQ;
                    state_d   = RUN;
                end
            end
            RUN: begin
                if (first_diff) begin
                    verdict_d = bit_gt ? V_GT : V_LT;
                end
                if (idx_q != '0) begin
                    idx_d = idx_q - IDX_W'(1);
                end
                if (run_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            verdict_q <= V_EQ;
            a_q       <= '0;
            b_q       <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            verdict_q <= verdict_d;
            a_q       <= a_d;
            b_q       <= b_d;
            idx_q     <= idx_d;
        end
    end

    assign onehot    = (state_q == DONE) ? verdict_onehot(verdict_q) : 3'b000;
    assign gt        = onehot[2];
    assign lt        = onehot[1];
    assign eq        = onehot[0];
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);

endmodule
